// File: rtl/seq_debug_cmd_mailbox.sv
// Host-to-sequencer debug command mailbox: Avalon-MM register window, valid/ready
// command hand-off to the sequencer core, completion tracking with a watchdog.
module seq_debug_cmd_mailbox #(
   parameter logic [31:0] DEBUG_BASE     = 32'h0001_53b4,
   parameter int          ADDR_WIDTH     = 20,
   parameter int          NUM_PARAMS     = 4,
   parameter int          CMD_WIDTH      = 8,
   parameter int          TIMEOUT_CYCLES = 65535,
   parameter logic [31:0] DEBUG_ID       = 32'h5D0B_0002
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     avl_address,
   input  logic                      avl_write,
   input  logic                      avl_read,
   input  logic [31:0]               avl_writedata,
   output logic [31:0]               avl_readdata,
   output logic                      avl_readdatavalid,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [CMD_WIDTH-1:0]      cmd_code,
   output logic [32*NUM_PARAMS-1:0]  cmd_params,
   input  logic                      cmd_done,
   input  logic [7:0]                cmd_result,
   output logic                      cmd_abort,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;

   localparam int AW2 = ADDR_WIDTH - 2;
   localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};
   localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(DEBUG_BASE);
   localparam logic [ADDR_WIDTH:0] WIN_HI = (ADDR_WIDTH+1)'(DEBUG_BASE + 32'(16 + 4*NUM_PARAMS));

   state_t          state;
   state_t          nxt;
   logic [CW-1:0]   cnt;
   logic [31:0]     req_cmd;
   logic [31:0]     params [NUM_PARAMS];
   logic [7:0]      result;
   logic            timeout;
   logic            overrun;

   logic            in_win;
   logic [AW2-1:0]  widx;
   logic [AW2-1:0]  pidx;
   logic            active;
   logic            wr_req;
   logic            wr_par;
   logic            wr_clr;
   logic            go_busy;
   logic            done_ev;
   logic            to_ev;
   logic [31:0]     rd_word;

   assign cmd_code = req_cmd[CMD_WIDTH-1:0];

   // Address decode and host write qualification
   always_comb begin
      in_win = ({1'b0, avl_address} >= WIN_LO) && ({1'b0, avl_address} < WIN_HI);
      widx   = avl_address[ADDR_WIDTH-1:2] - DEBUG_BASE[ADDR_WIDTH-1:2];
      pidx   = widx - AW2'(4);
      active = (state == PENDING) || (state == BUSY);
      wr_req = avl_write && in_win && (widx == AW2'(2));
      wr_clr = avl_write && in_win && (widx == AW2'(3)) && avl_writedata[31];
      wr_par = avl_write && in_win && (widx >= AW2'(4));
   end

   // Read data mux; parameter words are selected by their word index
   always_comb begin
      rd_word = 32'd0;
      if (widx == AW2'(0)) begin
         rd_word = DEBUG_ID;
      end else if (widx == AW2'(2)) begin
         rd_word = req_cmd;
      end else if (widx == AW2'(3)) begin
         rd_word = {16'd0, result, 4'd0, overrun, timeout, state};
      end else begin
         for (int i = 0; i < NUM_PARAMS; i++) begin
            if (widx >= AW2'(4) && pidx == AW2'(i)) begin
               rd_word = params[i];
            end else begin
               rd_word = rd_word;
            end
         end
      end
   end

   // Parameter words flattened onto the command bus
   always_comb begin
      cmd_params = '0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
         cmd_params[32*i +: 32] = params[i];
      end
   end

   // Next state: core events act on BUSY/PENDING, host writes are judged on the current state
   always_comb begin
      nxt     = state;
      go_busy = 1'b0;
      done_ev = 1'b0;
      to_ev   = 1'b0;
      case (state)
         PENDING: begin
            if (cmd_valid && cmd_ready) begin
               nxt     = BUSY;
               go_busy = 1'b1;
            end else begin
               nxt = PENDING;
            end
         end
         BUSY: begin
            if (cmd_done) begin
               nxt     = DONE;
               done_ev = 1'b1;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
               nxt   = DONE;
               to_ev = 1'b1;
            end else begin
               nxt = BUSY;
            end
         end
         IDLE, DONE: begin
            if (wr_req) begin
               nxt = PENDING;
            end else if (wr_clr && (state == DONE)) begin
               nxt = IDLE;
            end else begin
               nxt = state;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // State, handshake outputs, watchdog, flags and register file
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         cmd_valid         <= 1'b0;
         busy              <= 1'b0;
         cmd_abort         <= 1'b0;
         avl_readdatavalid <= 1'b0;
         avl_readdata      <= 32'd0;
         cnt               <= {CW{1'b0}};
         req_cmd           <= 32'd0;
         result            <= 8'd0;
         timeout           <= 1'b0;
         overrun           <= 1'b0;
         for (int i = 0; i < NUM_PARAMS; i++) begin
            params[i] <= 32'd0;
         end
      end else begin
         state             <= nxt;
         cmd_valid         <= (nxt == PENDING);
         busy              <= (nxt == PENDING) || (nxt == BUSY);
         cmd_abort         <= to_ev;
         avl_readdatavalid <= avl_read && in_win;
         avl_readdata      <= (avl_read && in_win) ? rd_word : 32'd0;

         if (go_busy) begin
            cnt <= {CW{1'b0}};
         end else if ((state == BUSY) && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
         end

         if (done_ev) begin
            result <= cmd_result;
         end else if (to_ev) begin
            result <= 8'hFF;
         end

         // The host clear is applied after any same-cycle core event
         if (wr_clr) begin
            timeout <= 1'b0;
            overrun <= 1'b0;
         end else begin
            if (to_ev) begin
               timeout <= 1'b1;
            end
            if ((wr_req || wr_par) && active) begin
               overrun <= 1'b1;
            end
         end

         if (wr_req && !active) begin
            req_cmd <= avl_writedata;
         end
         for (int i = 0; i < NUM_PARAMS; i++) begin
            if (wr_par && !active && (pidx == AW2'(i))) begin
               params[i] <= avl_writedata;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_debug_cmd_mailbox.sv
// Directed bench for seq_debug_cmd_mailbox: read responses go through a scoreboard
// queue checked by a monitor; handshake and watchdog timing are checked inline.
module tb_seq_debug_cmd_mailbox;

   localparam logic [19:0] BASE = 20'h153b4;
   localparam logic [19:0] A_ID  = BASE;
   localparam logic [19:0] A_REQ = BASE + 20'h8;
   localparam logic [19:0] A_STS = BASE + 20'hC;
   localparam logic [19:0] A_P0  = BASE + 20'h10;
   localparam logic [31:0] ID    = 32'h5D0B_0002;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [19:0]  avl_address = 20'd0;
   logic         avl_write = 1'b0;
   logic         avl_read = 1'b0;
   logic [31:0]  avl_writedata = 32'd0;
   logic [31:0]  avl_readdata;
   logic         avl_readdatavalid;
   logic         cmd_valid;
   logic         cmd_ready = 1'b0;
   logic [7:0]   cmd_code;
   logic [127:0] cmd_params;
   logic         cmd_done = 1'b0;
   logic [7:0]   cmd_result = 8'd0;
   logic         cmd_abort;
   logic         busy;

   typedef struct { logic [31:0] data; string name; } exp_t;
   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   seq_debug_cmd_mailbox #(
      .DEBUG_BASE(32'h0001_53b4), .ADDR_WIDTH(20), .NUM_PARAMS(4),
      .CMD_WIDTH(8), .TIMEOUT_CYCLES(16), .DEBUG_ID(32'h5D0B_0002)
   ) dut (
      .clk(clk), .reset(reset),
      .avl_address(avl_address), .avl_write(avl_write), .avl_read(avl_read),
      .avl_writedata(avl_writedata), .avl_readdata(avl_readdata),
      .avl_readdatavalid(avl_readdatavalid),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
      .cmd_params(cmd_params), .cmd_done(cmd_done), .cmd_result(cmd_result),
      .cmd_abort(cmd_abort), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every read response is matched against the scoreboard head
   always @(negedge clk) begin
      if (!reset && avl_readdatavalid) begin
         exp_t e;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_readdatavalid: data=%0h with no read outstanding", avl_readdata);
         end else begin
            e = sb.pop_front();
            if (avl_readdata !== e.data) begin
               bad++;
               $display("FAIL %s: got %08h expected %08h", e.name, avl_readdata, e.data);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Bus tasks are entered on a negedge and return on the following negedge
   task automatic bus_write(input logic [19:0] a, input logic [31:0] d);
      avl_address = a; avl_writedata = d; avl_write = 1'b1;
      @(negedge clk);
      avl_write = 1'b0;
   endtask

   task automatic bus_read(input logic [19:0] a, input logic [31:0] exp, input bit expv, input string nm);
      exp_t e;
      avl_address = a; avl_read = 1'b1;
      if (expv) begin
         e.data = exp; e.name = nm;
         sb.push_back(e);
      end
      @(negedge clk);
      avl_read = 1'b0;
      if (!expv) check({nm, "_no_rdv"}, {127'd0, avl_readdatavalid}, 128'd0);
   endtask

   // Starts a command and returns on the first negedge after the core accepted it
   task automatic start_busy(input logic [31:0] code, output int c0);
      bus_write(A_REQ, code);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      c0 = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "global timeout");
   end

   initial begin
      int vcnt;
      int first;
      int npulse;
      int c0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_cmd_valid", {127'd0, cmd_valid}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_abort", {127'd0, cmd_abort}, 128'd0);
      check("rst_code", {120'd0, cmd_code}, 128'd0);
      bus_read(A_STS, 32'h0, 1'b1, "rst_status");

      // Window decode and boundaries
      bus_read(A_ID, ID, 1'b1, "id");
      bus_read(BASE + 20'h4, 32'h0, 1'b1, "unmapped_4");
      bus_read(BASE - 20'h4, 32'h0, 1'b0, "below_window");
      bus_read(BASE + 20'h20, 32'h0, 1'b0, "above_window");
      bus_write(BASE + 20'h4, 32'hFFFF_FFFF);
      bus_write(A_ID, 32'h0);
      bus_read(BASE + 20'h4, 32'h0, 1'b1, "unmapped_4_after_write");
      bus_read(A_ID, ID, 1'b1, "id_after_write");

      // Command hand-off with a slow core
      bus_write(A_P0, 32'h1234);
      bus_write(A_P0 + 20'hC, 32'hCAFE);
      bus_write(A_REQ, 32'h07);
      check("pend_code", {120'd0, cmd_code}, 128'h07);
      check("pend_param3", {96'd0, cmd_params[127:96]}, 128'hCAFE);
      check("pend_param0", {96'd0, cmd_params[31:0]}, 128'h1234);
      check("pend_busy", {127'd0, busy}, 128'd1);
      vcnt = 0;
      for (int i = 0; i < 7; i++) begin
         if (cmd_valid) vcnt++;
         if (i == 0) begin
            exp_t e;
            avl_address = A_STS; avl_read = 1'b1;
            e.data = 32'h1; e.name = "status_pending";
            sb.push_back(e);
         end
         if (i == 1) avl_read = 1'b0;
         if (i == 3) cmd_ready = 1'b1;
         if (i == 4) cmd_ready = 1'b0;
         @(negedge clk);
      end
      check("cmd_valid_cycles", 128'(vcnt), 128'd4);
      bus_read(A_STS, 32'h2, 1'b1, "status_busy");

      // Normal completion and clear
      cmd_done = 1'b1; cmd_result = 8'h00;
      @(negedge clk);
      cmd_done = 1'b0;
      bus_read(A_STS, 32'h3, 1'b1, "status_done");
      bus_write(A_STS, 32'h8000_0000);
      bus_read(A_STS, 32'h0, 1'b1, "status_cleared");

      // Watchdog timeout
      start_busy(32'h07, c0);
      first = -1; npulse = 0;
      for (int k = 0; k < 30; k++) begin
         if (cmd_abort) begin
            if (first < 0) first = k;
            npulse++;
         end
         @(negedge clk);
      end
      check("abort_latency", 128'(first), 128'd16);
      check("abort_width", 128'(npulse), 128'd1);
      bus_read(A_STS, 32'h0000_FF07, 1'b1, "status_timeout");
      bus_write(A_STS, 32'h8000_0000);
      bus_read(A_STS, 32'h0000_FF00, 1'b1, "status_timeout_cleared");

      // Overrun while BUSY, then done coinciding with the watchdog limit
      start_busy(32'h07, c0);
      bus_write(A_REQ, 32'h09);
      bus_write(A_P0, 32'h1);
      check("overrun_code", {120'd0, cmd_code}, 128'h07);
      bus_read(A_P0, 32'h1234, 1'b1, "overrun_param0");
      bus_read(A_STS, 32'h0000_FF0A, 1'b1, "status_overrun");
      for (int w = 0; w < 20 && cyc < c0 + 15; w++) @(negedge clk);
      check("race_setup_cycle", 128'(cyc - c0), 128'd15);
      cmd_done = 1'b1; cmd_result = 8'h3C;
      @(negedge clk);
      cmd_done = 1'b0;
      check("race_no_abort", {127'd0, cmd_abort}, 128'd0);
      check("race_not_busy", {127'd0, busy}, 128'd0);
      bus_read(A_STS, 32'h0000_3C0B, 1'b1, "status_race");
      bus_write(A_STS, 32'h8000_0000);
      bus_read(A_STS, 32'h0000_3C00, 1'b1, "status_race_cleared");

      // Asynchronous reset during PENDING
      bus_write(A_P0 + 20'h4, 32'h55);
      bus_write(A_REQ, 32'h0A);
      check("pre_reset_valid", {127'd0, cmd_valid}, 128'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_valid", {127'd0, cmd_valid}, 128'd0);
      check("async_reset_busy", {127'd0, busy}, 128'd0);
      check("async_reset_code", {120'd0, cmd_code}, 128'd0);
      check("async_reset_params", cmd_params, 128'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus_read(A_ID, ID, 1'b1, "post_reset_id");
      bus_read(A_REQ, 32'h0, 1'b1, "post_reset_req");
      bus_read(A_STS, 32'h0, 1'b1, "post_reset_status");
      for (int i = 0; i < 4; i++) begin
         bus_read(A_P0 + 20'(4*i), 32'h0, 1'b1, $sformatf("post_reset_param%0d", i));
      end
      @(negedge clk);
      check("scoreboard_drained", 128'(sb.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_debug_cmd_mailbox.md
Name: seq_debug_cmd_mailbox

Overview:
Parametrised host-to-sequencer debug command mailbox. It decodes a memory-mapped debug window at DEBUG_BASE on the sequencer's Avalon-MM slave bus, holding one command word, a status word and NUM_PARAMS parameter words. It hands each command to the sequencer core through a valid/ready handshake, tracks completion with a timeout watchdog, and reports the result, timeout and overrun flags back to the host. It sits between the debug/JTAG master and the sequencer core.

Parameters:
DEBUG_BASE, 'h000153b4, byte address of the debug window (word aligned)
ADDR_WIDTH, 20, avl_address width in bits (byte address)
NUM_PARAMS, 4, number of 32-bit parameter registers (1..16)
CMD_WIDTH, 8, width of the command code taken from REQ_CMD[CMD_WIDTH-1:0]
TIMEOUT_CYCLES, 65535, maximum BUSY cycles before abort (0 = watchdog disabled)
DEBUG_ID, 'h5D0B0002, constant returned at offset 0x0

Ports:
clk  in  1  sequencer/Avalon clock
reset  in  1  asynchronous, active-high reset
avl_address  in  ADDR_WIDTH  byte address
avl_write  in  1  write strobe
avl_read  in  1  read strobe
avl_writedata  in  32  write data
avl_readdata  out  32  read data, valid with avl_readdatavalid
avl_readdatavalid  out  1  one-cycle read response
cmd_valid  out  1  command offered to the sequencer core
cmd_ready  in  1  core accepts the command
cmd_code  out  CMD_WIDTH  latched command code
cmd_params  out  32*NUM_PARAMS  parameter words, word i at [32i+31:32i]
cmd_done  in  1  core completion pulse
cmd_result  in  8  core result code, sampled with cmd_done
cmd_abort  out  1  one-cycle pulse on watchdog timeout
busy  out  1  high in PENDING or BUSY

Behaviour:
- Register map (offset from DEBUG_BASE):
  - 0x0 ID (RO).
  - 0x8 REQ_CMD (RW).
  - 0xC CMD_STATUS.
  - 0x10 + 4i PARAM[i] (RW).
- Inside the window (DEBUG_BASE .. DEBUG_BASE+0x10+4*NUM_PARAMS-1):
  - Read latency is exactly 1 cycle: avl_readdatavalid pulses the cycle after avl_read.
  - Unmapped offsets read 0 and ignore writes.
- Outside the window: no readdatavalid and no side effects.
- CMD_STATUS layout:
  - [1:0] state (0 IDLE, 1 PENDING, 2 BUSY, 3 DONE).
  - [2] timeout, sticky.
  - [3] overrun, sticky.
  - [15:8] last result.
  - Other bits read 0.
- State machine:
  - IDLE/DONE + write REQ_CMD: latch cmd_code, go PENDING. cmd_valid is high the next cycle.
  - PENDING: cmd_valid=1. cmd_valid && cmd_ready moves to BUSY next cycle, drops cmd_valid and clears the watchdog counter.
  - BUSY: counter increments each cycle.
    - cmd_done moves to DONE and latches cmd_result.
    - Otherwise, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: go DONE, set timeout, pulse cmd_abort, result = 'hFF.
    - cmd_done and timeout in the same cycle: done wins, no abort, timeout not set.
  - DONE: write CMD_STATUS with bit31=1 goes to IDLE.
- Sticky flags:
  - A write of CMD_STATUS with bit31=1 clears timeout and overrun in any state.
  - This clear does not change PENDING/BUSY.
- Overrun: a write to REQ_CMD or PARAM[i] while PENDING or BUSY is ignored and sets overrun. Params are stable for the whole command.
- cmd_done outside BUSY is ignored.
- Same-cycle ordering:
  - Host write and core event in the same cycle: the core event updates state first; the host write is then judged against the pre-update state.
  - Exception: a REQ_CMD write in the same cycle as a BUSY->DONE transition is an overrun.
- Counter width: clog2(TIMEOUT_CYCLES+1), saturating, no wrap.
- Reset (asynchronous, any state, mid-command included):
  - State IDLE.
  - cmd_valid, cmd_abort, avl_readdatavalid, busy = 0.
  - avl_readdata, cmd_code, cmd_params, result, flags, counter = 0.
  - A command in flight is dropped silently.

Test Plan:
- Read DEBUG_BASE+0x0 -> avl_readdatavalid one cycle later with 'h5D0B0002. Read DEBUG_BASE+0x4 -> 0. Read DEBUG_BASE-4 -> no readdatavalid.
- Write PARAM0='h1234, PARAM3='hCAFE, REQ_CMD='h07; cmd_ready held 0 for 3 cycles then 1 -> cmd_valid high 4 cycles, cmd_code='h07, cmd_params word3='hCAFE. STATUS reads 1 then 2.
- In BUSY, pulse cmd_done with cmd_result='h00 -> STATUS='h00000003. Write STATUS 'h80000000 -> STATUS=0.
- TIMEOUT_CYCLES=16, never assert cmd_done -> cmd_abort pulses exactly 16 cycles after entry to BUSY. STATUS='h0000FF07.
- In BUSY, write REQ_CMD='h09 and PARAM0='h1 -> cmd_code stays 'h07, PARAM0 unchanged, overrun=1. Same-cycle cmd_done and timeout -> DONE, timeout=0, no cmd_abort.
- Assert reset during PENDING -> cmd_valid low immediately (asynchronous), all registers read 0 after release.
